// File: rtl/iomem_bus_pkg.sv
// ----------------------------------------------------------------------------
// iomem_bus_pkg
// Shared types and helpers for the picosoc iomem to Wishbone interconnect.
//   bus_state_t       : handshake FSM states (IDLE, ACCESS, RESP)
//   region_base_t     : one 8-bit address-region match value (iomem_addr[31:24])
//   DEFAULT_ERR_DATA  : read word returned for unmapped or timed-out accesses
//   slave_data_lsb()  : bit position of slave k's read word in the packed bus
// ----------------------------------------------------------------------------
package iomem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } bus_state_t;

  typedef logic [7:0] region_base_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Slave read words are packed with slave 0 in the least significant slot,
  // so slave k's word starts at bit k*dataW of wbm_dat_i.
  function automatic int slave_data_lsb(input int k, input int dataW);
    return k * dataW;
  endfunction

endpackage

// File: rtl/iomem_addr_decoder.sv
// ----------------------------------------------------------------------------
// iomem_addr_decoder
// Combinational region decode of the iomem address top byte.
// Ports:
//   i_addr_top   : iomem_addr[31:24]
//   i_slave_base : packed N_SLAVES x 8-bit match values, slave 0 in the LSB byte
//   o_hit_vec    : one-hot select of the matching slave (all zero when unmapped)
//   o_hit        : at least one slave matched
//   o_idx        : encoded index of the selected slave
// ----------------------------------------------------------------------------
module iomem_addr_decoder
  import iomem_bus_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int IDX_W    = 1
) (
  input  region_base_t            i_addr_top,
  input  logic [N_SLAVES*8-1:0]   i_slave_base,
  output logic [N_SLAVES-1:0]     o_hit_vec,
  output logic                    o_hit,
  output logic [IDX_W-1:0]        o_idx
);

  // Scan from the highest index down so that, when two regions share a base,
  // the lowest-numbered slave is the one left selected at the end.
  always_comb begin
    o_hit     = 1'b0;
    o_idx     = '0;
    o_hit_vec = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (region_base_t'(i_slave_base[k*8 +: 8]) == i_addr_top) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(k);
      end
    end
    if (o_hit) begin
      o_hit_vec[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/iomem_wb_interconnect.sv
// ----------------------------------------------------------------------------
// iomem_wb_interconnect
// Bridges the picosoc iomem bus onto N Wishbone classic slave ports with a
// registered handshake, a bus-timeout watchdog and a sticky error log.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   iomem_valid/ready/wstrb/addr/wdata/rdata : picosoc memory-mapped IO bus
//   wbm_cyc_o, wbm_stb_o        : per-slave cycle and strobe
//   wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o : shared request signals
//   wbm_dat_i, wbm_ack_i        : packed slave read data and per-slave acks
//   err_o, err_addr_o, err_clr_i : sticky error flag, first error address, clear
// ----------------------------------------------------------------------------
module iomem_wb_interconnect
  import iomem_bus_pkg::*;
#(
  parameter int                       N_SLAVES       = 2,
  parameter int                       DATA_W         = 32,
  parameter logic [N_SLAVES*8-1:0]    SLAVE_BASE     = {8'h30, 8'h03},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]        ERR_DATA       = DATA_W'(DEFAULT_ERR_DATA),
  localparam int                      SEL_W          = DATA_W / 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        iomem_valid,
  output logic                        iomem_ready,
  input  logic [SEL_W-1:0]            iomem_wstrb,
  input  logic [31:0]                 iomem_addr,
  input  logic [DATA_W-1:0]           iomem_wdata,
  output logic [DATA_W-1:0]           iomem_rdata,
  output logic [N_SLAVES-1:0]         wbm_cyc_o,
  output logic [N_SLAVES-1:0]         wbm_stb_o,
  output logic                        wbm_we_o,
  output logic [SEL_W-1:0]            wbm_sel_o,
  output logic [31:0]                 wbm_addr_o,
  output logic [DATA_W-1:0]           wbm_dat_o,
  input  logic [N_SLAVES*DATA_W-1:0]  wbm_dat_i,
  input  logic [N_SLAVES-1:0]         wbm_ack_i,
  output logic                        err_o,
  output logic [31:0]                 err_addr_o,
  input  logic                        err_clr_i
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [N_SLAVES-1:0]  r_cyc;
  logic                 r_we;
  logic [SEL_W-1:0]     r_sel;
  logic [31:0]          r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_ready;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_guard;
  logic                 r_err;
  logic [31:0]          r_errAddr;

  logic [N_SLAVES-1:0]  w_hitVec;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hitIdx;
  logic                 w_ack;
  logic [DATA_W-1:0]    w_slaveData;
  logic                 w_launch;
  logic                 w_timeoutHit;
  logic                 w_newErr;
  logic [31:0]          w_newErrAddr;

  iomem_addr_decoder #(
    .N_SLAVES (N_SLAVES),
    .IDX_W    (IDX_W)
  ) u_decoder (
    .i_addr_top   (iomem_addr[31:24]),
    .i_slave_base (SLAVE_BASE),
    .o_hit_vec    (w_hitVec),
    .o_hit        (w_hit),
    .o_idx        (w_hitIdx)
  );

  // Only the latched slave's ack and read word matter; everything else on the
  // return side is ignored. A new request is accepted only from IDLE and not in
  // the turnaround cycle right after a response, since picosoc may still be
  // holding valid for the request that just completed.
  assign w_ack        = wbm_ack_i[r_idx];
  assign w_slaveData  = wbm_dat_i[slave_data_lsb(32'(r_idx), DATA_W) +: DATA_W];
  assign w_launch     = (r_state == ST_IDLE) && iomem_valid && !r_guard;
  assign w_timeoutHit = (r_state == ST_ACCESS) && !w_ack && (r_cnt == CNT_LAST);
  assign w_newErr     = (w_launch && !w_hit) || w_timeoutHit;
  assign w_newErrAddr = (r_state == ST_IDLE) ? iomem_addr : r_addr;

  // Handshake FSM plus error log. ready and rdata default low every cycle and
  // are only raised on the edge entering RESP, which makes ready a one-cycle
  // pulse. An ack arriving on the last counted cycle wins over the timeout.
  // The error log keeps the first error until cleared, but a clear landing on
  // the same edge as a fresh error records that fresh error.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_cyc     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_guard   <= 1'b0;
      r_err     <= 1'b0;
      r_errAddr <= '0;
    end else begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_guard <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            if (w_hit) begin
              r_idx   <= w_hitIdx;
              r_cyc   <= w_hitVec;
              r_we    <= |iomem_wstrb;
              r_sel   <= (|iomem_wstrb) ? iomem_wstrb : '1;
              r_addr  <= iomem_addr;
              r_wdata <= iomem_wdata;
              r_cnt   <= '0;
              r_state <= ST_ACCESS;
            end else begin
              r_ready <= 1'b1;
              r_rdata <= ERR_DATA;
              r_state <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (w_ack) begin
            r_cyc   <= '0;
            r_ready <= 1'b1;
            r_rdata <= r_we ? '0 : w_slaveData;
            r_state <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_cyc   <= '0;
            r_ready <= 1'b1;
            r_rdata <= ERR_DATA;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_cnt   <= '0;
          r_guard <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cyc   <= '0;
          r_state <= ST_IDLE;
        end
      endcase

      if (w_newErr && (!r_err || err_clr_i)) begin
        r_err     <= 1'b1;
        r_errAddr <= w_newErrAddr;
      end else if (err_clr_i) begin
        r_err     <= 1'b0;
        r_errAddr <= '0;
      end
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_addr_o  = r_addr;
  assign wbm_dat_o   = r_wdata;
  assign err_o       = r_err;
  assign err_addr_o  = r_errAddr;

endmodule

// File: tb/tb_iomem_wb_interconnect.sv
// ----------------------------------------------------------------------------
// tb_iomem_wb_interconnect
// Self-checking bench for iomem_wb_interconnect: table vectors, hand-written
// corner sequences and randomized transactions against a transaction-level
// reference model. Slave 0 answers at 0x30xx_xxxx, slave 1 at 0x03xx_xxxx,
// and the watchdog is shortened to 8 cycles.
// ----------------------------------------------------------------------------
module tb_iomem_wb_interconnect;

  localparam int          N   = 2;
  localparam int          DW  = 32;
  localparam int          T   = 8;
  localparam logic [15:0] BASES = {8'h03, 8'h30};
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          iomem_valid;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb;
  logic [31:0]   iomem_addr;
  logic [31:0]   iomem_wdata;
  logic [31:0]   iomem_rdata;
  logic [N-1:0]  wbm_cyc_o;
  logic [N-1:0]  wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_addr_o;
  logic [31:0]   wbm_dat_o;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N-1:0]  wbm_ack_i;
  logic          err_o;
  logic [31:0]   err_addr_o;
  logic          err_clr_i;

  iomem_wb_interconnect #(
    .N_SLAVES       (N),
    .DATA_W         (DW),
    .SLAVE_BASE     (BASES),
    .TIMEOUT_CYCLES (T),
    .ERR_DATA       (ERRD)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_addr_o  (wbm_addr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .err_o       (err_o),
    .err_addr_o  (err_addr_o),
    .err_clr_i   (err_clr_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit          mErr;
  logic [31:0] mErrAddr;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          ackDelay;
    logic [31:0] sdata;
    bit          otherAck;
    int          expLat;
    logic [31:0] expRd;
    bit          expErr;
    int          expTgt;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Transaction-level reference: which slave, how many cycles to ready, what
  // data comes back and whether it is an error, from the decode/timeout rules.
  function automatic void predict(input logic [31:0] addr, input logic [3:0] wstrb,
                                  input int ackDelay, input logic [31:0] sdata,
                                  output int tgt, output int lat,
                                  output logic [31:0] rd, output bit err);
    logic [15:0] bases;
    bases = BASES;
    tgt = -1;
    for (int k = 0; k < N; k++) begin
      if (tgt < 0 && bases[k*8 +: 8] == addr[31:24]) tgt = k;
    end
    if (tgt < 0) begin
      lat = 1; rd = ERRD; err = 1'b1;
    end else if (ackDelay < T) begin
      lat = ackDelay + 2; rd = (wstrb != 4'b0) ? 32'h0 : sdata; err = 1'b0;
    end else begin
      lat = T + 1; rd = ERRD; err = 1'b1;
    end
  endfunction

  // Runs one iomem request from a negedge. The slave model acks the selected
  // slave on its ackDelay-th strobed cycle (never if ackDelay >= T) and fills
  // the other read slot with noise; otherAck makes the other slave ack every
  // cycle. holdValid keeps valid asserted through the turnaround cycle.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input int ackDelay, input logic [31:0] sdata,
                               input bit otherAck, input bit clrAtStart, input bit holdValid,
                               input int expLat, input logic [31:0] expRd, input bit expErr,
                               input int expTgt);
    int          c = 0;
    int          stbCnt = 0;
    int          lat = -1;
    logic [31:0] rd = '0;
    bit          wrongStb = 1'b0;
    bit          cycDiff = 1'b0;
    bit          unstable = 1'b0;
    logic [31:0] sAddr = '0;
    logic [31:0] sDat = '0;
    logic        sWe = 1'b0;
    logic [3:0]  sSel = '0;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    err_clr_i   = clrAtStart;
    while (lat < 0 && c < 40) begin
      nextCycle();
      c++;
      err_clr_i = 1'b0;
      wbm_ack_i = '0;
      wbm_dat_i = {$urandom(), $urandom()};
      if (wbm_cyc_o !== wbm_stb_o) cycDiff = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (wbm_stb_o[k] && k != expTgt) wrongStb = 1'b1;
        if (otherAck && k != expTgt) wbm_ack_i[k] = 1'b1;
      end
      if (expTgt >= 0 && wbm_stb_o[expTgt]) begin
        if (stbCnt == 0) begin
          sAddr = wbm_addr_o; sDat = wbm_dat_o; sWe = wbm_we_o; sSel = wbm_sel_o;
        end else if (wbm_addr_o !== sAddr || wbm_dat_o !== sDat || wbm_we_o !== sWe || wbm_sel_o !== sSel) begin
          unstable = 1'b1;
        end
        if (stbCnt == ackDelay) begin
          wbm_ack_i[expTgt] = 1'b1;
          wbm_dat_i[expTgt*DW +: DW] = sdata;
        end
        stbCnt++;
      end
      if (iomem_ready === 1'b1) begin
        lat = c;
        rd  = iomem_rdata;
      end
    end
    if (clrAtStart) begin
      mErr = 1'b0; mErrAddr = '0;
    end
    if (expErr && !mErr) begin
      mErr = 1'b1; mErrAddr = addr;
    end
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " rdata"}, rd, expRd);
    checkOutput({tag, " stb cycles"}, stbCnt, (expTgt < 0) ? 0 : expLat - 1);
    checkOutput({tag, " stray stb"}, {31'b0, wrongStb}, 32'h0);
    checkOutput({tag, " cyc/stb differ"}, {31'b0, cycDiff}, 32'h0);
    checkOutput({tag, " err_o"}, {31'b0, err_o}, {31'b0, mErr});
    checkOutput({tag, " err_addr_o"}, err_addr_o, mErrAddr);
    if (expTgt >= 0) begin
      checkOutput({tag, " shared unstable"}, {31'b0, unstable}, 32'h0);
      checkOutput({tag, " addr_o"}, sAddr, addr);
      checkOutput({tag, " dat_o"}, sDat, wdata);
      checkOutput({tag, " we_o"}, {31'b0, sWe}, {31'b0, |wstrb});
      checkOutput({tag, " sel_o"}, {28'b0, sSel}, {28'b0, (wstrb != 4'b0) ? wstrb : 4'hF});
    end
    if (!holdValid) iomem_valid = 1'b0;
    wbm_ack_i = '0;
    wbm_dat_i = '0;
    nextCycle();
    checkOutput({tag, " ready pulse"}, {31'b0, iomem_ready}, 32'h0);
    checkOutput({tag, " stb after resp"}, {30'b0, wbm_stb_o}, 32'h0);
    if (holdValid) begin
      nextCycle();
      checkOutput({tag, " guard stb"}, {30'b0, wbm_stb_o}, 32'h0);
      checkOutput({tag, " guard ready"}, {31'b0, iomem_ready}, 32'h0);
      iomem_valid = 1'b0;
    end
    nextCycle();
    checkOutput({tag, " idle stb"}, {30'b0, wbm_stb_o}, 32'h0);
  endtask

  task automatic pulseClear(input string tag);
    err_clr_i = 1'b1;
    nextCycle();
    err_clr_i = 1'b0;
    mErr = 1'b0;
    mErrAddr = '0;
    checkOutput({tag, " err_o"}, {31'b0, err_o}, 32'h0);
    checkOutput({tag, " err_addr_o"}, err_addr_o, 32'h0);
  endtask

  task automatic runModel(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int ackDelay, input logic [31:0] sdata,
                          input bit otherAck, input bit clrAtStart, input bit holdValid);
    int          tgt;
    int          lat;
    logic [31:0] rd;
    bit          err;
    predict(addr, wstrb, ackDelay, sdata, tgt, lat, rd, err);
    applyStimulus(tag, addr, wstrb, wdata, ackDelay, sdata, otherAck, clrAtStart, holdValid,
                  lat, rd, err, tgt);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0300_0000, 4'b0000, 32'h0000_0000, 0,  32'h1234_5678, 1'b0, 2, 32'h1234_5678, 1'b0, 1};
    vecs[1] = '{32'h3000_0010, 4'b0011, 32'hA5A5_5A5A, 5,  32'h1111_2222, 1'b0, 7, 32'h0000_0000, 1'b0, 0};
    vecs[2] = '{32'h3000_0020, 4'b0000, 32'h0000_0000, 7,  32'hCAFE_F00D, 1'b0, 9, 32'hCAFE_F00D, 1'b0, 0};
    vecs[3] = '{32'h03FF_FFF0, 4'b0000, 32'h0000_0000, 3,  32'h0BAD_C0DE, 1'b1, 5, 32'h0BAD_C0DE, 1'b0, 1};
    vecs[4] = '{32'h0300_0004, 4'b1111, 32'h89AB_CDEF, 2,  32'h5555_AAAA, 1'b1, 4, 32'h0000_0000, 1'b0, 1};
    vecs[5] = '{32'h0500_0000, 4'b0000, 32'h0000_0000, 0,  32'h0000_0000, 1'b0, 1, ERRD,          1'b1, -1};
    vecs[6] = '{32'h0400_0000, 4'b1000, 32'h7777_7777, 0,  32'h0000_0000, 1'b1, 1, ERRD,          1'b1, -1};

    rst = 1'b1;
    iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
    wbm_dat_i = '0; wbm_ack_i = '0; err_clr_i = 1'b0;
    mErr = 1'b0; mErrAddr = '0;
    repeat (3) nextCycle();
    checkOutput("reset ready", {31'b0, iomem_ready}, 32'h0);
    checkOutput("reset cyc", {30'b0, wbm_cyc_o}, 32'h0);
    checkOutput("reset rdata", iomem_rdata, 32'h0);
    checkOutput("reset addr_o", wbm_addr_o, 32'h0);
    checkOutput("reset err_o", {31'b0, err_o}, 32'h0);
    rst = 1'b0;
    nextCycle();

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wstrb, vecs[i].wdata,
                    vecs[i].ackDelay, vecs[i].sdata, vecs[i].otherAck, 1'b0, 1'b0,
                    vecs[i].expLat, vecs[i].expRd, vecs[i].expErr, vecs[i].expTgt);
    end
    checkOutput("log kept first addr", err_addr_o, 32'h0500_0000);

    pulseClear("clear1");

    applyStimulus("timeout1", 32'h3000_0100, 4'b0000, 32'h0, 100, 32'h0, 1'b0, 1'b0, 1'b0,
                  T + 1, ERRD, 1'b1, 0);
    applyStimulus("timeout2", 32'h0300_0200, 4'b0101, 32'h1357_9BDF, 100, 32'h0, 1'b1, 1'b0, 1'b0,
                  T + 1, ERRD, 1'b1, 1);
    checkOutput("timeout log addr", err_addr_o, 32'h3000_0100);
    pulseClear("clear2");

    applyStimulus("unmapA", 32'h7700_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0,
                  1, ERRD, 1'b1, -1);
    applyStimulus("unmapB clr", 32'h8800_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0,
                  1, ERRD, 1'b1, -1);
    checkOutput("clr+err log addr", err_addr_o, 32'h8800_0000);
    pulseClear("clear3");

    applyStimulus("guard", 32'h3000_0040, 4'b0000, 32'h0, 1, 32'h2468_ACE0, 1'b0, 1'b0, 1'b1,
                  3, 32'h2468_ACE0, 1'b0, 0);

    wbm_ack_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("spurious ack ready", {31'b0, iomem_ready}, 32'h0);
      checkOutput("spurious ack stb", {30'b0, wbm_stb_o}, 32'h0);
    end
    wbm_ack_i = '0;

    iomem_valid = 1'b1; iomem_addr = 32'h0300_0010; iomem_wstrb = 4'b0000;
    repeat (4) nextCycle();
    checkOutput("pre-reset stb", {30'b0, wbm_stb_o}, 32'h2);
    rst = 1'b1;
    iomem_valid = 1'b0;
    nextCycle();
    checkOutput("mid reset cyc", {30'b0, wbm_cyc_o}, 32'h0);
    checkOutput("mid reset stb", {30'b0, wbm_stb_o}, 32'h0);
    checkOutput("mid reset ready", {31'b0, iomem_ready}, 32'h0);
    mErr = 1'b0; mErrAddr = '0;
    rst = 1'b0;
    nextCycle();
    applyStimulus("after reset", 32'h0300_0010, 4'b0000, 32'h0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0,
                  2, 32'h0F0F_0F0F, 1'b0, 1);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      logic [3:0]  ws;
      int          sel;
      sel = $urandom_range(0, 2);
      a = $urandom();
      if (sel == 0) a[31:24] = 8'h30;
      else if (sel == 1) a[31:24] = 8'h03;
      else if (a[31:24] == 8'h30 || a[31:24] == 8'h03) a[31:24] = 8'hEE;
      ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      runModel($sformatf("rand%0d", i), a, ws, $urandom(), $urandom_range(0, 9), $urandom(),
               $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
